// File: rtl/hazard_forward_unit_pkg.sv
// Shared encodings for the hazard/forwarding unit: operand-mux selects,
// stage-entry bit layout and the stage-priority helper.
package hazard_forward_unit_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  // Stage entry is packed as {rd, load, rf_e, v}; rd width is set by the user.
  localparam int unsigned ENT_V      = 0;
  localparam int unsigned ENT_RF_E   = 1;
  localparam int unsigned ENT_LOAD   = 2;
  localparam int unsigned ENT_RD     = 3;
  localparam int unsigned ENT_CTRL_W = 3;

  typedef struct packed {
    logic ex;
    logic mem;
    logic wb;
  } stage_hit_t;

  // Youngest producer wins when several stages write the same register.
  function automatic fwd_sel_e fwd_prio(input stage_hit_t hit);
    if (hit.ex)       return FWD_EX;
    else if (hit.mem) return FWD_MEM;
    else if (hit.wb)  return FWD_WB;
    else              return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// ID-stage request / forwarding-response bundle between the decode stage
// (master) and the hazard/forwarding unit (slave).
interface hazard_forward_unit_if #(
  parameter int unsigned RA_W      = 4,
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned CNT_W     = 16
);

  logic                      id_valid;
  logic [NUM_PORTS*RA_W-1:0] id_rs;
  logic [NUM_PORTS-1:0]      id_rs_used;
  logic [RA_W-1:0]           id_rd;
  logic                      id_rf_e;
  logic                      id_load;
  logic                      flush;
  logic [NUM_PORTS*2-1:0]    fwd_sel;
  logic                      stall;
  logic [CNT_W-1:0]          stall_count;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rd, id_rf_e, id_load, flush,
    input  fwd_sel, stall, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rd, id_rf_e, id_load, flush,
    output fwd_sel, stall, stall_count
  );

endinterface

// File: rtl/hazard_forward_unit_stage_entry.sv
// One pipeline-stage destination record {rd, load, rf_e, v} with async
// active-low clear; a bubble loads an all-zero (invalid) entry.
module hfu_stage_entry
  import hazard_forward_unit_pkg::*;
#(
  parameter int unsigned RA_W = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       bubble_i,
  input  logic [RA_W+ENT_CTRL_W-1:0] ent_d_i,
  output logic [RA_W+ENT_CTRL_W-1:0] ent_q_o
);

  logic [RA_W+ENT_CTRL_W-1:0] ent_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent_q <= '0;
    end else if (bubble_i) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d_i;
    end
  end

  assign ent_q_o = ent_q;

endmodule

// File: rtl/hazard_forward_unit.sv
// Data-hazard and forwarding controller for the 5-stage pipeline: EX/MEM/WB
// destination tracking, per-port forward selects, load-use stall and stall counter.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int unsigned RA_W      = 4,
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned PC_REG    = 15,
  parameter int unsigned CNT_W     = 16
) (
  input  logic clk,
  input  logic reset,
  hazard_forward_unit_if.slave hfu
);

  localparam int unsigned ENT_W = RA_W + ENT_CTRL_W;

  logic [ENT_W-1:0]       id_ent;
  logic [ENT_W-1:0]       ex_ent;
  logic [ENT_W-1:0]       mem_ent;
  logic [ENT_W-1:0]       wb_ent;
  logic                   ex_bubble;
  logic                   stall;
  logic [NUM_PORTS-1:0]   load_hit;
  logic [NUM_PORTS*2-1:0] fwd_sel;
  logic [RA_W-1:0]        rs;
  logic                   rs_fwdable;
  stage_hit_t             hit;
  logic [CNT_W-1:0]       stall_cnt_q;
  logic [CNT_W-1:0]       stall_cnt_d;

  function automatic logic produces(input logic [ENT_W-1:0] ent,
                                    input logic [RA_W-1:0]  reg_a);
    return ent[ENT_V] && ent[ENT_RF_E] && (ent[ENT_RD +: RA_W] == reg_a);
  endfunction

  always_comb begin
    id_ent                = '0;
    id_ent[ENT_V]         = 1'b1;
    id_ent[ENT_RF_E]      = hfu.id_rf_e;
    id_ent[ENT_LOAD]      = hfu.id_load;
    id_ent[ENT_RD +: RA_W] = hfu.id_rd;
  end

  // Flush outranks stall; either one turns the EX slot into a bubble.
  assign ex_bubble = !(hfu.id_valid && !stall && !hfu.flush);

  hfu_stage_entry #(.RA_W(RA_W)) u_ex (
    .clk_i    (clk),
    .rst_ni   (reset),
    .bubble_i (ex_bubble),
    .ent_d_i  (id_ent),
    .ent_q_o  (ex_ent)
  );

  hfu_stage_entry #(.RA_W(RA_W)) u_mem (
    .clk_i    (clk),
    .rst_ni   (reset),
    .bubble_i (1'b0),
    .ent_d_i  (ex_ent),
    .ent_q_o  (mem_ent)
  );

  hfu_stage_entry #(.RA_W(RA_W)) u_wb (
    .clk_i    (clk),
    .rst_ni   (reset),
    .bubble_i (1'b0),
    .ent_d_i  (mem_ent),
    .ent_q_o  (wb_ent)
  );

  // Per-port compare and priority; the PC register is never forwarded or stalled on.
  always_comb begin
    fwd_sel    = '0;
    load_hit   = '0;
    rs         = '0;
    rs_fwdable = 1'b0;
    hit        = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      rs         = hfu.id_rs[p*RA_W +: RA_W];
      rs_fwdable = hfu.id_rs_used[p] && (rs != RA_W'(PC_REG));
      hit.ex     = rs_fwdable && produces(ex_ent, rs);
      hit.mem    = rs_fwdable && produces(mem_ent, rs);
      hit.wb     = rs_fwdable && produces(wb_ent, rs);
      fwd_sel[p*2 +: 2] = fwd_prio(hit);
      load_hit[p]       = hit.ex && ex_ent[ENT_LOAD];
    end
  end

  assign stall = hfu.id_valid && !hfu.flush && (|load_hit);

  assign stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1
                                                      : stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hfu.fwd_sel     = fwd_sel;
  assign hfu.stall       = stall;
  assign hfu.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed-vector bench for hazard_forward_unit; a second narrow-counter
// instance shares the stimulus so counter saturation is reachable quickly.
module tb_hazard_forward_unit;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  hazard_forward_unit_if #(.RA_W(4), .NUM_PORTS(3), .CNT_W(16)) hfu_m ();
  hazard_forward_unit_if #(.RA_W(4), .NUM_PORTS(3), .CNT_W(4))  hfu_s ();

  hazard_forward_unit #(.RA_W(4), .NUM_PORTS(3), .PC_REG(15), .CNT_W(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .hfu   (hfu_m.slave)
  );

  hazard_forward_unit #(.RA_W(4), .NUM_PORTS(3), .PC_REG(15), .CNT_W(4)) u_dut_small (
    .clk   (clk),
    .reset (reset),
    .hfu   (hfu_s.slave)
  );

  assign hfu_s.id_valid   = hfu_m.id_valid;
  assign hfu_s.id_rs      = hfu_m.id_rs;
  assign hfu_s.id_rs_used = hfu_m.id_rs_used;
  assign hfu_s.id_rd      = hfu_m.id_rd;
  assign hfu_s.id_rf_e    = hfu_m.id_rf_e;
  assign hfu_s.id_load    = hfu_m.id_load;
  assign hfu_s.flush      = hfu_m.flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [2:0] used,
                     input logic [3:0] pa, input logic [3:0] pb, input logic [3:0] pd,
                     input logic [3:0] rd, input logic rfe, input logic ld, input logic fl);
    hfu_m.id_valid   = v;
    hfu_m.id_rs_used = used;
    hfu_m.id_rs      = {pd, pb, pa};
    hfu_m.id_rd      = rd;
    hfu_m.id_rf_e    = rfe;
    hfu_m.id_load    = ld;
    hfu_m.flush      = fl;
    #2;
  endtask

  task automatic idle();
    drv(1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (3) step();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    idle();

    // 1. reset held, then released with nothing valid
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_fwd", hfu_m.fwd_sel, 6'h00);
      check_eq("rst_stall", hfu_m.stall, 1'b0);
      check_eq("rst_cnt", hfu_m.stall_count, 16'd0);
    end
    step();
    reset = 1'b1;
    step();
    step();
    check_eq("post_rst_fwd", hfu_m.fwd_sel, 6'h00);
    check_eq("post_rst_stall", hfu_m.stall, 1'b0);
    check_eq("post_rst_cnt", hfu_m.stall_count, 16'd0);

    // 2. ADD r1 then repeated reads of r1 on PA: EX, MEM, WB, RF
    drv(1'b1, 3'b000, 4'd0, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
    step();
    drv(1'b1, 3'b001, 4'd1, 4'd0, 4'd0, 4'd6, 1'b0, 1'b0, 1'b0);
    check_eq("alu_fwd_ex", hfu_m.fwd_sel, 6'h01);
    check_eq("alu_no_stall", hfu_m.stall, 1'b0);
    step();
    check_eq("alu_fwd_mem", hfu_m.fwd_sel, 6'h02);
    step();
    check_eq("alu_fwd_wb", hfu_m.fwd_sel, 6'h03);
    step();
    check_eq("alu_fwd_rf", hfu_m.fwd_sel, 6'h00);

    // 3. LDR r2 then ADD reading r2 on PB: one-cycle load-use stall
    drain();
    drv(1'b1, 3'b000, 4'd0, 4'd0, 4'd0, 4'd2, 1'b1, 1'b1, 1'b0);
    step();
    drv(1'b1, 3'b010, 4'd0, 4'd2, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0);
    check_eq("lu_stall", hfu_m.stall, 1'b1);
    check_eq("lu_fwd_ex", hfu_m.fwd_sel, 6'h04);
    check_eq("lu_cnt0", hfu_m.stall_count, 16'd0);
    step();
    check_eq("lu_unstall", hfu_m.stall, 1'b0);
    check_eq("lu_fwd_mem", hfu_m.fwd_sel, 6'h08);
    check_eq("lu_cnt1", hfu_m.stall_count, 16'd1);
    step();
    idle();
    check_eq("lu_cnt_hold", hfu_m.stall_count, 16'd1);

    // 4. r3 written in EX and WB, r7 in MEM; PA reads r7, PD reads r3
    drain();
    drv(1'b1, 3'b000, 4'd0, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0);
    step();
    drv(1'b1, 3'b000, 4'd0, 4'd0, 4'd0, 4'd7, 1'b1, 1'b0, 1'b0);
    step();
    drv(1'b1, 3'b000, 4'd0, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0);
    step();
    drv(1'b1, 3'b101, 4'd7, 4'd0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0);
    check_eq("prio_ex_wins", hfu_m.fwd_sel, 6'h12);
    check_eq("prio_no_stall", hfu_m.stall, 1'b0);

    // 5. flush masks a load-use stall and squashes the ID op
    drain();
    drv(1'b1, 3'b000, 4'd0, 4'd0, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0);
    step();
    drv(1'b1, 3'b001, 4'd4, 4'd0, 4'd0, 4'd8, 1'b1, 1'b0, 1'b1);
    check_eq("flush_no_stall", hfu_m.stall, 1'b0);
    check_eq("flush_fwd_ex", hfu_m.fwd_sel, 6'h01);
    step();
    drv(1'b1, 3'b011, 4'd8, 4'd4, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    check_eq("flush_squashed", hfu_m.fwd_sel, 6'h08);
    check_eq("flush_stall_after", hfu_m.stall, 1'b0);
    check_eq("flush_cnt", hfu_m.stall_count, 16'd1);

    // 6. PC register is never forwarded or stalled on
    drain();
    drv(1'b1, 3'b000, 4'd0, 4'd0, 4'd0, 4'd15, 1'b1, 1'b1, 1'b0);
    step();
    drv(1'b1, 3'b111, 4'd15, 4'd15, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0);
    check_eq("pc_fwd", hfu_m.fwd_sel, 6'h00);
    check_eq("pc_stall", hfu_m.stall, 1'b0);

    // Saturation: 2^4+5 stalls on the 4-bit counter, plain count on the 16-bit one
    drain();
    for (int i = 0; i < 21; i++) begin
      drv(1'b1, 3'b000, 4'd0, 4'd0, 4'd0, 4'd9, 1'b1, 1'b1, 1'b0);
      step();
      drv(1'b1, 3'b001, 4'd9, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      check_eq("sat_stall", hfu_m.stall, 1'b1);
      step();
    end
    idle();
    check_eq("sat_small_cnt", hfu_s.stall_count, 4'hF);
    check_eq("sat_big_cnt", hfu_m.stall_count, 16'd22);

    // Reset mid-operation drops in-flight entries at once
    drv(1'b1, 3'b000, 4'd0, 4'd0, 4'd0, 4'd10, 1'b1, 1'b1, 1'b0);
    step();
    drv(1'b1, 3'b001, 4'd10, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    check_eq("midrst_pre_stall", hfu_m.stall, 1'b1);
    reset = 1'b0;
    #1;
    check_eq("midrst_stall", hfu_m.stall, 1'b0);
    check_eq("midrst_fwd", hfu_m.fwd_sel, 6'h00);
    check_eq("midrst_cnt", hfu_m.stall_count, 16'd0);
    check_eq("midrst_small_cnt", hfu_s.stall_count, 4'h0);
    step();
    reset = 1'b1;
    step();
    check_eq("postrst_fwd", hfu_m.fwd_sel, 6'h00);
    check_eq("postrst_stall", hfu_m.stall, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
